// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program-counter stage of the single-cycle MIPS core. Holds the
//             30-bit word PC and presents it to instruction memory with a
//             valid/ready handshake. Selects sequential, branch, jump and
//             jump-register targets, sequences BOOT/RUN/HALT, and counts
//             retired instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] imm_ext,
    input  logic [25:0] jtarget,
    input  logic [31:0] jr_addr,
    input  logic        beq,
    input  logic        bne,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic        jr,
    input  logic        halt,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [29:0] pc,
    output logic [31:0] pc_byte,
    output logic [29:0] pc_plus1,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] retire_count
);

    localparam logic [1:0] c_BOOT = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [29:0] r_pc;
    logic [31:0] r_retire_count;
    logic        r_fetch_valid;
    logic        r_halted;

    logic [29:0] w_pc_plus1;
    logic [29:0] w_next_pc;
    logic        w_adv;
    logic        w_taken;
    logic        w_unused_jr_lsb;

    // Byte-offset bits of a JR target are dropped; keep them visibly consumed.
    assign w_unused_jr_lsb = ^jr_addr[1:0];

    assign w_pc_plus1 = r_pc + 30'd1;
    assign w_adv      = (r_state == c_RUN) & imem_ready & ~stall;
    assign w_taken    = (beq & alu_zero) | (bne & ~alu_zero);

    // Next-PC select: JR beats J/JAL, which beats a taken branch.
    always_comb begin
        w_next_pc = w_pc_plus1;
        if (jr) begin
            w_next_pc = jr_addr[31:2];
        end else if (jump) begin
            w_next_pc = {w_pc_plus1[29:26], jtarget};
        end else if (w_taken) begin
            w_next_pc = w_pc_plus1 + imm_ext;
        end
    end

    // Boot/run/halt sequencing with registered fetch_valid and halted flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_BOOT;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                c_BOOT: begin
                    r_state       <= c_RUN;
                    r_fetch_valid <= 1'b1;
                    r_halted      <= 1'b0;
                end
                c_RUN: begin
                    if (w_adv && halt) begin
                        r_state       <= c_HALT;
                        r_fetch_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end
                end
                c_HALT: begin
                    r_state       <= c_HALT;
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
                default: begin
                    r_state       <= c_BOOT;
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    // PC register: advances only on an accepted, non-halting fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_adv && !halt) begin
            r_pc <= w_next_pc;
        end
    end

    // Retired-instruction counter, including the halting instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire_count <= 32'd0;
        end else if (w_adv) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign pc           = r_pc;
    assign pc_plus1     = w_pc_plus1;
    assign pc_byte      = {r_pc, 2'b00};
    assign fetch_valid  = r_fetch_valid;
    assign halted       = r_halted;
    assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Scoreboard bench for pc_unit. A driver applies directed vectors
//             on the falling edge and queues the expected post-edge state; a
//             monitor pops and compares after every rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic [29:0] imm_ext;
    logic [25:0] jtarget;
    logic [31:0] jr_addr;
    logic        beq, bne, alu_zero, jump, jr, halt, stall, imem_ready;
    logic [29:0] pc;
    logic [31:0] pc_byte;
    logic [29:0] pc_plus1;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] retire_count;

    pc_unit #(.RESET_PC(30'h100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imm_ext      (imm_ext),
        .jtarget      (jtarget),
        .jr_addr      (jr_addr),
        .beq          (beq),
        .bne          (bne),
        .alu_zero     (alu_zero),
        .jump         (jump),
        .jr           (jr),
        .halt         (halt),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .pc           (pc),
        .pc_byte      (pc_byte),
        .pc_plus1     (pc_plus1),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .retire_count (retire_count)
    );

    typedef struct packed {
        logic [29:0] pc;
        logic        fv;
        logic        h;
        logic [31:0] rc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_step   = 0;
    logic [31:0] m_rc     = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s step %0d got %h want %h", name, n_step, got, want);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t        e;
        logic [29:0] p1;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                p1 = e.pc + 30'd1;
                chk("pc",           {2'b00, pc},          {2'b00, e.pc});
                chk("fetch_valid",  {31'd0, fetch_valid}, {31'd0, e.fv});
                chk("halted",       {31'd0, halted},      {31'd0, e.h});
                chk("retire_count", retire_count,         e.rc);
                chk("pc_plus1",     {2'b00, pc_plus1},    {2'b00, p1});
                chk("pc_byte",      pc_byte,              {e.pc, 2'b00});
                n_step++;
            end
        end
    end

    // Move to the next falling edge with idle controls, memory ready.
    task automatic nxt();
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        stall      = 1'b0;
        beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
        jump = 1'b0; jr = 1'b0; halt = 1'b0;
        imm_ext = 30'd0; jtarget = 26'd0; jr_addr = 32'd0;
    endtask

    task automatic expect_state(input logic [29:0] p, input logic fv, input logic h);
        q.push_back('{pc: p, fv: fv, h: h, rc: m_rc});
    endtask

    // An accepted fetch: the counter model advances with it.
    task automatic expect_adv(input logic [29:0] p);
        m_rc = m_rc + 32'd1;
        expect_state(p, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0;
        beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
        jump = 1'b0; jr = 1'b0; halt = 1'b0;
        imm_ext = 30'd0; jtarget = 26'd0; jr_addr = 32'd0;

        // Reset for two edges, then boot and three sequential fetches
        for (int i = 0; i < 2; i++) begin
            nxt(); rst_n = 1'b0; m_rc = 32'd0; expect_state(30'h100, 1'b0, 1'b0);
        end
        nxt(); expect_state(30'h100, 1'b1, 1'b0);
        nxt(); expect_adv(30'h101);
        nxt(); expect_adv(30'h102);
        nxt(); expect_adv(30'h103);

        // Branches
        nxt(); jr = 1'b1; jr_addr = 32'h0000_0080; expect_adv(30'h20);
        nxt(); beq = 1'b1; alu_zero = 1'b1; imm_ext = 30'd23; expect_adv(30'h38);
        nxt(); bne = 1'b1; alu_zero = 1'b1; imm_ext = 30'd23; expect_adv(30'h39);
        nxt(); beq = 1'b1; alu_zero = 1'b1; imm_ext = 30'h3FFF_FFE9; expect_adv(30'h23);
        nxt(); bne = 1'b1; alu_zero = 1'b0; imm_ext = 30'd5; expect_adv(30'h29);
        nxt(); beq = 1'b1; alu_zero = 1'b0; imm_ext = 30'd5; expect_adv(30'h2A);

        // Jumps and priority
        nxt(); jr = 1'b1; jr_addr = 32'h8000_0014; expect_adv(30'h2000_0005);
        nxt(); jump = 1'b1; jtarget = 26'h123; expect_adv(30'h2000_0123);
        nxt(); jr = 1'b1; jump = 1'b1; jtarget = 26'h3; jr_addr = 32'h0000_0404;
        expect_adv(30'h101);

        // Not-ready then stalled, with a taken branch held on the inputs
        for (int i = 0; i < 5; i++) begin
            nxt(); beq = 1'b1; alu_zero = 1'b1; imm_ext = 30'h10;
            if (i < 3) imem_ready = 1'b0;
            else stall = 1'b1;
            expect_state(30'h101, 1'b1, 1'b0);
        end
        nxt(); beq = 1'b1; alu_zero = 1'b1; imm_ext = 30'h10; expect_adv(30'h112);

        // PC wrap; JR low bits discarded
        nxt(); jr = 1'b1; jr_addr = 32'hFFFF_FFFF; expect_adv(30'h3FFF_FFFF);
        nxt(); expect_adv(30'h0);

        // Counter wrap from a preset value
        nxt();
        force dut.r_retire_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_retire_count;
        m_rc = 32'hFFFF_FFFE;
        expect_adv(30'h1);
        nxt(); expect_adv(30'h2);

        // Halt beats a simultaneous jump, then everything freezes
        nxt(); jr = 1'b1; jr_addr = 32'h0000_0100; expect_adv(30'h40);
        nxt(); halt = 1'b1; jump = 1'b1; jtarget = 26'h3FF;
        m_rc = m_rc + 32'd1;
        expect_state(30'h40, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            nxt(); jump = 1'(i % 2); halt = 1'(i % 3 == 0); beq = 1'b1; alu_zero = 1'b1;
            imm_ext = 30'h7;
            expect_state(30'h40, 1'b0, 1'b1);
        end

        // Recovery through reset
        nxt(); rst_n = 1'b0; m_rc = 32'd0; expect_state(30'h100, 1'b0, 1'b0);
        nxt(); expect_state(30'h100, 1'b1, 1'b0);
        nxt(); expect_adv(30'h101);

        // Drain the scoreboard within a bounded number of cycles
        nxt();
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
